target_editor: RTL and testbench
================================

TARGET_EDITOR -- requirements
Module: target_editor

Interface
REQ-001 Parameter TARGET_W, default 32, width of the edited target word.
REQ-002 Parameter FIELD_W, default 8, width of one editable field; TARGET_W SHALL be a multiple of FIELD_W.
REQ-003 Parameter VAL_W, default 6, user value width; SHALL satisfy VAL_W <= FIELD_W.
REQ-004 Parameter DEFAULT, default 32'h4996CDD1, target value after reset and revert.
REQ-005 Parameter DB_CYC, default 50000, debounce length in clock cycles, >= 1.
REQ-006 Derived: NFIELD = TARGET_W/FIELD_W; POS_W = max(1, clog2(NFIELD)).
REQ-007 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 sw_val  input  VAL_W  user value from switches.
REQ-010 sw_pos  input  POS_W  field index; 0 = least significant field.
REQ-011 btn_load  input  1  raw pushbutton, asynchronous, active-high: write field.
REQ-012 btn_revert  input  1  raw pushbutton, asynchronous, active-high: restore DEFAULT.
REQ-013 target  output  TARGET_W  current target word, registered.
REQ-014 upd_valid  output  1  new target offered to consumer.
REQ-015 upd_ready  input  1  consumer accepts offered target.
REQ-016 busy  output  1  high while an offer is pending; equals upd_valid.

Function
REQ-017 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-018 Per button: the debounce counter increments while the synchronised input is high, clears when it is low, and saturates at DB_CYC; the debounced level is 1 while the counter equals DB_CYC, else 0.
REQ-019 A press event SHALL be a single-cycle pulse on the 0->1 transition of the debounced level; holding a button SHALL produce exactly one event.
REQ-020 Field value = {sw_val, (FIELD_W-VAL_W) zero bits}; sw_val and sw_pos SHALL be sampled in the event cycle.
REQ-021 FSM states: IDLE, OFFER.
REQ-022 IDLE, load event, sw_pos < NFIELD: on the next edge, target SHALL become the old target with bits [sw_pos*FIELD_W +: FIELD_W] replaced by the field value, upd_valid SHALL be 1, and the state SHALL be OFFER.
REQ-023 IDLE, load event, sw_pos >= NFIELD: event SHALL be ignored; target and state unchanged.
REQ-024 IDLE, revert event: on the next edge, target SHALL become DEFAULT, upd_valid SHALL be 1, and the state SHALL be OFFER.
REQ-025 Simultaneous load and revert events: revert SHALL win.
REQ-026 A load producing an unchanged target SHALL still be offered.
REQ-027 OFFER: target and upd_valid SHALL be held stable; all events SHALL be dropped.
REQ-028 OFFER with upd_ready=1: upd_valid SHALL drop and the state SHALL be IDLE on the next edge; minimum offer length is 1 cycle.
REQ-029 upd_ready SHALL be ignored in IDLE.
REQ-030 Debounce counters SHALL run in both states, so a press held through OFFER does not produce an event after acceptance.

Reset
REQ-031 While rst=1 at a clock edge: target=DEFAULT, upd_valid=0, busy=0, state=IDLE, synchronisers, counters and debounced levels = 0.
REQ-032 Reset during OFFER SHALL discard the offer without a handshake.
REQ-033 A button held high through reset release SHALL produce one event, DB_CYC+2 cycles after release.

Verification (DB_CYC=4, other parameters default)
REQ-034 Reset -> target=0x4996CDD1, upd_valid=0, busy=0.
REQ-035 upd_ready=1, sw_pos=0, sw_val=6'h3F, btn_load high 10 cycles -> target=0x4996CDFC, upd_valid high exactly 1 cycle, one update only.
REQ-036 sw_pos=3, sw_val=6'h01, load press -> target=0x0496CDD1.
REQ-037 btn_load high 3 cycles then low -> no upd_valid, target unchanged.
REQ-038 upd_ready=0, sw_pos=1, sw_val=6'h10, load press -> target=0x499640D1 with upd_valid held. Second press with sw_pos=0 -> dropped. Then upd_ready=1 -> upd_valid falls next cycle and target stays 0x499640D1.
REQ-039 After an edit, btn_load and btn_revert rise in the same cycle -> target=0x4996CDD1 and a single offer.

Source files
------------

// File: rtl/target_editor.sv
// Field-wise editor for a TARGET_W-bit word driven by switches and two debounced
// pushbuttons; every new value is offered once through a valid/ready handshake.
module target_editor #(
  parameter int unsigned              TARGET_W = 32,
  parameter int unsigned              FIELD_W  = 8,
  parameter int unsigned              VAL_W    = 6,
  parameter logic [TARGET_W-1:0]      DEFAULT  = 32'h4996CDD1,
  parameter int unsigned              DB_CYC   = 50000,
  localparam int unsigned             NFIELD   = TARGET_W / FIELD_W,
  localparam int unsigned             POS_W    = (NFIELD > 1) ? $clog2(NFIELD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VAL_W-1:0]    sw_val,
  input  logic [POS_W-1:0]    sw_pos,
  input  logic                btn_load,
  input  logic                btn_revert,
  output logic [TARGET_W-1:0] target,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(DB_CYC + 1);
  localparam logic [CNT_W-1:0] DbMax = CNT_W'(DB_CYC);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e state_q, state_d;
  logic [TARGET_W-1:0] target_q, target_d;

  // Index 0 = load button, index 1 = revert button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       lvl, lvl_q;
  logic [1:0]       ev;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign btn_raw = {btn_revert, btn_load};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DbMax) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      lvl[i] = (cnt_q[i] == DbMax);
    end
  end

  assign ev = lvl & ~lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  logic [FIELD_W-1:0]  field;
  logic [TARGET_W-1:0] loaded;
  logic                pos_hit;

  // Out-of-range positions match no field, so pos_hit stays low.
  always_comb begin
    field   = FIELD_W'(sw_val) << (FIELD_W - VAL_W);
    loaded  = target_q;
    pos_hit = 1'b0;
    for (int i = 0; i < NFIELD; i++) begin
      if (sw_pos == POS_W'(i)) begin
        loaded[i*FIELD_W +: FIELD_W] = field;
        pos_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      StIdle: begin
        if (ev[1]) begin
          target_d = DEFAULT;
          state_d  = StOffer;
        end else if (ev[0] && pos_hit) begin
          target_d = loaded;
          state_d  = StOffer;
        end
      end
      StOffer: begin
        if (upd_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= DEFAULT;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign target    = target_q;
  assign upd_valid = (state_q == StOffer);
  assign busy      = upd_valid;

endmodule

// File: tb/tb_target_editor.sv
// Randomised and directed bench for target_editor, checked every cycle against a
// window-based behavioural model of the debounced buttons and the edit handshake.
module tb_target_editor;

  localparam int unsigned DB   = 4;
  localparam int unsigned NF   = 4;
  localparam logic [31:0] DEFV = 32'h4996CDD1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  sw_val = '0;
  logic [1:0]  sw_pos = '0;
  logic        btn_load = 1'b0;
  logic        btn_revert = 1'b0;
  logic        upd_ready = 1'b0;
  logic [31:0] target;
  logic        upd_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  target_editor #(
    .TARGET_W(32),
    .FIELD_W (8),
    .VAL_W   (6),
    .DEFAULT (DEFV),
    .DB_CYC  (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_val    (sw_val),
    .sw_pos    (sw_pos),
    .btn_load  (btn_load),
    .btn_revert(btn_revert),
    .target    (target),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw-sample history per button (bit 0 = latest edge). A button reads as
  // pressed once it was high for DB consecutive samples ending two edges back.
  logic [DB+2:0] hl = '0, hr = '0;
  logic [31:0]   m_target = DEFV;
  logic          m_valid = 1'b0;
  logic          m_ok = 1'b0;

  always @(posedge clk) begin
    logic el, er;
    if (rst) begin
      hl = '0;
      hr = '0;
      m_target = DEFV;
      m_valid  = 1'b0;
      m_ok     = 1'b1;
    end else begin
      el = (&hl[2 +: DB]) && !(&hl[3 +: DB]);
      er = (&hr[2 +: DB]) && !(&hr[3 +: DB]);
      if (m_valid) begin
        if (upd_ready) m_valid = 1'b0;
      end else if (er) begin
        m_target = DEFV;
        m_valid  = 1'b1;
      end else if (el && (int'(sw_pos) < NF)) begin
        m_target[sw_pos*8 +: 8] = {sw_val, 2'b00};
        m_valid = 1'b1;
      end
      hl = {hl[DB+1:0], btn_load};
      hr = {hr[DB+1:0], btn_revert};
    end
  end

  int  valid_rises = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("target", target, m_target);
      chk("upd_valid", 32'(upd_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_valid));
    end
    if (upd_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
    prev_valid = upd_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic press_load(input int len);
    btn_load = 1'b1;
    cycles(len);
    btn_load = 1'b0;
    cycles(DB + 6);
  endtask

  int r0;

  initial begin
    do_reset();
    chk("reset_target", target, 32'h4996CDD1);
    chk("reset_valid", 32'(upd_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    upd_ready = 1'b1; sw_pos = 2'd0; sw_val = 6'h3F;
    r0 = valid_rises;
    press_load(10);
    chk("load_f0", target, 32'h4996CDFC);
    chk("load_f0_offers", 32'(valid_rises - r0), 32'd1);

    do_reset();
    sw_pos = 2'd3; sw_val = 6'h01;
    press_load(DB + 2);
    chk("load_f3", target, 32'h0496CDD1);

    r0 = valid_rises;
    sw_pos = 2'd0; sw_val = 6'h00;
    press_load(3);
    chk("short_press_target", target, 32'h0496CDD1);
    chk("short_press_offers", 32'(valid_rises - r0), 32'd0);

    do_reset();
    upd_ready = 1'b0; sw_pos = 2'd1; sw_val = 6'h10;
    press_load(DB + 2);
    chk("offer_target", target, 32'h499640D1);
    chk("offer_held", 32'(upd_valid), 32'd1);
    sw_pos = 2'd0; sw_val = 6'h2A;
    press_load(DB + 2);
    chk("dropped_target", target, 32'h499640D1);
    upd_ready = 1'b1;
    cycles(1);
    chk("accept_valid", 32'(upd_valid), 32'd0);
    chk("accept_target", target, 32'h499640D1);

    r0 = valid_rises;
    btn_load = 1'b1; btn_revert = 1'b1;
    cycles(DB + 4);
    btn_load = 1'b0; btn_revert = 1'b0;
    cycles(DB + 4);
    chk("revert_wins", target, 32'h4996CDD1);
    chk("revert_offers", 32'(valid_rises - r0), 32'd1);

    // Button held through reset release yields exactly one event.
    sw_pos = 2'd2; sw_val = 6'h05;
    btn_load = 1'b1;
    do_reset();
    r0 = valid_rises;
    cycles(DB + 8);
    btn_load = 1'b0;
    cycles(4);
    chk("held_reset_offers", 32'(valid_rises - r0), 32'd1);
    chk("held_reset_target", target, 32'h4914CDD1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sw_val    = 6'($urandom);
      sw_pos    = 2'($urandom);
      upd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) btn_load = ~btn_load;
      if ($urandom_range(0, 15) == 0) btn_revert = ~btn_revert;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
